aes_decrypt_ctrl: RTL

//  Iterative AES-128 decryption sequencer. Accepts one 128-bit ciphertext block over a valid/ready handshake.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/de_last_round.sv | 10 +
 rtl/de_round.sv | 14 +
 rtl/aes_decrypt_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: block/round constants, controller state encoding and
// the inverse-cipher byte transforms used by both round datapaths.
package aes_pkg;
  localparam int AES_BLK_W = 128;
  localparam int AES128_NR = 10;

  typedef enum logic [1:0] {IDLE, ROUND, LAST, DONE} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(x, x);
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      acc = gf_mul(acc, sq);
      sq  = gf_mul(sq, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  // Byte i of the block sits at bits [127-8i -: 8]; bytes are column-major (i = row + 4*col).
  function automatic logic [AES_BLK_W-1:0] inv_shift_sub(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction
endpackage

// File: rtl/de_last_round.sv
// Final inverse round: InvShiftRows, InvSubBytes, AddRoundKey, no InvMixColumns.
module de_last_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] st,
  input  logic [AES_BLK_W-1:0] rk,
  output logic [AES_BLK_W-1:0] res
);
  assign res = inv_shift_sub(st) ^ rk;
endmodule

// File: rtl/de_round.sv
// One full inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module de_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] st,
  input  logic [AES_BLK_W-1:0] rk,
  output logic [AES_BLK_W-1:0] res
);
  logic [AES_BLK_W-1:0] keyed;

  assign keyed = inv_shift_sub(st) ^ rk;
  assign res = {inv_mix_col(keyed[127:96]), inv_mix_col(keyed[95:64]),
                inv_mix_col(keyed[63:32]), inv_mix_col(keyed[31:0])};
endmodule

// File: rtl/aes_decrypt_ctrl.sv
// Iterative AES-128 decryption sequencer: one block in, NR inverse rounds against
// an external round-key store, one block out, valid/ready on both sides.
module aes_decrypt_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = AES128_NR,
  parameter int KIDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] ciphertext,
  output logic [KIDX_W-1:0]    rk_idx,
  input  logic [AES_BLK_W-1:0] rk_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] plaintext,
  output logic                 busy
);
  localparam logic [KIDX_W-1:0] KIDX_NR  = KIDX_W'(NR);
  localparam logic [KIDX_W-1:0] KIDX_ONE = KIDX_W'(1);

  state_t               state, state_nxt;
  logic [KIDX_W-1:0]    r;
  logic [AES_BLK_W-1:0] st;
  logic [AES_BLK_W-1:0] round_out;
  logic [AES_BLK_W-1:0] last_out;
  logic                 accept;

  de_round u_round (.st(st), .rk(rk_data), .res(round_out));
  de_last_round u_last (.st(st), .rk(rk_data), .res(last_out));

  assign busy   = (state != IDLE);
  assign accept = in_valid && in_ready;

  // in_ready is masked by rst so a handshake can never coincide with reset.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    rk_idx    = KIDX_NR;
    unique case (state)
      IDLE: begin
        in_ready = key_valid && !rst;
        if (in_valid && key_valid && !rst) state_nxt = ROUND;
      end
      ROUND: begin
        rk_idx = r;
        if (r == KIDX_ONE) state_nxt = LAST;
      end
      LAST: begin
        rk_idx    = '0;
        state_nxt = DONE;
      end
      DONE: begin
        rk_idx = '0;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      out_valid <= 1'b0;
      plaintext <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE:  if (accept) r <= KIDX_W'(NR - 1);
        ROUND: r <= r - KIDX_ONE;
        LAST: begin
          out_valid <= 1'b1;
          plaintext <= last_out;
        end
        DONE:  if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Working state needs no reset: it is always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) st <= ciphertext ^ rk_data;
    else if (state == ROUND)     st <= round_out;
  end
endmodule
